scudsp_dma_seq: RTL
===================

// Module: scudsp_dma_seq
// PURPOSE
// - Parametrised DMA sequencer for the SCU DSP; executes one decoded DMA instruction per START.
// - Moves words between the external D0 bus and an NBANK data-RAM set or program RAM; each transfer is one DMA instruction.
// - Sits between the DSP decode/ctrl stage and the A/B-bus arbiter.
// - Generalises the fixed 4-bank / 8-bit-count DMA to N banks, configurable count width and full increment table in both directions.
// PARAMETERS
// NBANK   4   number of data-RAM banks (power of 2, 2..8)
// RAM_AW  6   data-RAM word address width (per bank)
// PRG_AW  8   program-RAM word address width
// EXT_AW  25  external word address width
// CNT_W   8   transfer count width; count 0 means 2**CNT_W words
// DATA_W  32  data word width
// PORTS
// CLK        in   1         system clock
// RST_N      in   1         asynchronous reset, active-low
// CE         in   1         clock enable; all state advances only when CE=1
// START      in   1         start pulse; sampled in IDLE only
// DIR        in   1         0: D0->RAM, 1: RAM->D0
// RAMW       in   NBANK     one-hot destination bank (DIR=0, PRGW=0)
// PRGW       in   1         destination is program RAM (DIR=0)
// RAMS       in   log2(NBANK) source bank (DIR=1)
// ADDI       in   3         increment code: 0->0, k->2**(k-1) words
// CNT        in   CNT_W     word count, latched at START
// HOLD       in   1         1: do not write back final external address
// EXT_A0     in   EXT_AW    start external address (RA0 or WA0 per DIR)
// RAM_CT     in   NBANK*RAM_AW  current per-bank CT values
// BUSY       out  1         transfer in progress
// DONE       out  1         one-cycle pulse at completion
// EXT_REQ    out  1         external bus request
// EXT_WE     out  1         external write (=DIR while EXT_REQ)
// EXT_ADDR   out  EXT_AW    external word address
// EXT_DOUT   out  DATA_W    write data to D0
// EXT_DIN    in   DATA_W    read data from D0
// EXT_ACK    in   1         bus acknowledge, completes one word
// RAM_RE     out  NBANK     one-hot bank read strobe
// RAM_WE     out  NBANK     one-hot bank write strobe
// RAM_WDATA  out  DATA_W    bank write data
// RAM_RDATA  in   NBANK*DATA_W  bank read data, valid 1 cycle after RAM_RE
// PRG_WE     out  1         program-RAM write strobe
// PRG_ADDR   out  PRG_AW    program-RAM address (internal counter, starts at 0)
// CT_INC     out  NBANK     one-hot CT post-increment pulse per word
// A0_WB      out  1         pulse: write back EXT_A0_NEXT to RA0/WA0
// A0_NEXT    out  EXT_AW    final external address
// BEHAVIOUR
// - Reset: FSM=IDLE; all outputs 0; internal count/address regs 0.
// - States: IDLE -> (DIR? RD : REQ) on START&CE. RD: assert RAM_RE[RAMS] one cycle -> REQ.
// - REQ: EXT_REQ=1 held until EXT_ACK. On ACK: DIR=0 writes EXT_DIN to RAM_WE[bank]/PRG_WE same cycle;
//   pulse CT_INC[bank] (not for PRGW); EXT_ADDR += inc; count-1; -> FIN if count reached 0 else (DIR? RD : REQ).
// - FIN: DONE=1, A0_WB=!HOLD with A0_NEXT=EXT_ADDR; -> IDLE. BUSY=1 in RD/REQ/FIN.
// - Min 2 cycles/word RAM->D0, 1 cycle/word D0->RAM (ACK same cycle as REQ allowed).
// - Increment: DIR=0 uses ADDI[0] only (0 or 1 word); DIR=1 full table 0..64. EXT_ADDR wraps mod 2**EXT_AW.
// - Bank address = RAM_CT slice; RAM_AW wrap handled by CT owner. PRG_ADDR wraps mod 2**PRG_AW.
// - CNT=0 -> 2**CNT_W words. START while BUSY ignored; START with zero-hot RAMW and PRGW=0 in DIR=0:
//   bus cycles still run, no RAM write.
// - Reset mid-transfer: immediate IDLE, EXT_REQ drops, no DONE/A0_WB.
// - CE=0: state frozen, strobes RAM_WE/PRG_WE/CT_INC/DONE/A0_WB gated low; EXT_ACK ignored.
// CONFIGURATION
// - SCUDSP_DMA_ABORT_EN defined: adds input ABORT (1). ABORT in RD/REQ: finish the current word if ACK
//   in same cycle, else drop EXT_REQ; go to FIN with DONE=1, A0_WB=0. ABORT in IDLE/FIN ignored.
// - Not defined: no ABORT port; transfers always run to count exhaustion.
// CONFIGURATION DEFAULT: macro undefined.
// TESTING
// - D0->bank1, CNT=3, ADDI=1, EXT_A0=0x100, ACK every cycle -> RAM_WE[1] x3, CT_INC[1] x3, DONE at cycle 5, A0_NEXT=0x103.
// - bank2->D0, CNT=2, ADDI=3 (4 words), EXT_A0=0x1FFFFFE -> EXT_ADDR 0x1FFFFFE, 0x0000002 (wrap), A0_NEXT=0x6.
// - D0->PRG, CNT=0, HOLD=1 -> 256 PRG_WE, PRG_ADDR 0..255, DONE, A0_WB=0.
// - ACK delayed 3 cycles per word, CE toggling 50% -> identical RAM writes and counts to CE=1 run, no extra strobes.
// - RST_N low during word 2 of CNT=5 -> outputs 0 asynchronously, no DONE; next START runs fresh.
// - (ABORT_EN) ABORT in REQ of word 2 of CNT=4, no ACK -> EXT_REQ drops, DONE next cycle, A0_WB=0.

Source files
------------

// File: rtl/scudsp_dma_seq.sv
// SCU DSP DMA sequencer: one DMA instruction per START, D0 bus <-> data-RAM banks / program RAM.
// Optional ABORT input enabled by defining SCUDSP_DMA_ABORT_EN.
module scudsp_dma_seq #(
  parameter int unsigned NBANK  = 4,
  parameter int unsigned RAM_AW = 6,
  parameter int unsigned PRG_AW = 8,
  parameter int unsigned EXT_AW = 25,
  parameter int unsigned CNT_W  = 8,
  parameter int unsigned DATA_W = 32,
  localparam int unsigned BSW   = (NBANK > 1) ? $clog2(NBANK) : 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_ce,
  input  logic                     i_start,
  input  logic                     i_dir,
  input  logic [NBANK-1:0]         i_ramw,
  input  logic                     i_prgw,
  input  logic [BSW-1:0]           i_rams,
  input  logic [2:0]               i_addi,
  input  logic [CNT_W-1:0]         i_cnt,
  input  logic                     i_hold,
  input  logic [EXT_AW-1:0]        i_ext_a0,
  input  logic [NBANK*RAM_AW-1:0]  i_ram_ct,
  output logic                     o_busy,
  output logic                     o_done,
  output logic                     o_ext_req,
  output logic                     o_ext_we,
  output logic [EXT_AW-1:0]        o_ext_addr,
  output logic [DATA_W-1:0]        o_ext_dout,
  input  logic [DATA_W-1:0]        i_ext_din,
  input  logic                     i_ext_ack,
  output logic [NBANK-1:0]         o_ram_re,
  output logic [NBANK-1:0]         o_ram_we,
  output logic [DATA_W-1:0]        o_ram_wdata,
  input  logic [NBANK*DATA_W-1:0]  i_ram_rdata,
  output logic                     o_prg_we,
  output logic [PRG_AW-1:0]        o_prg_addr,
  output logic [NBANK-1:0]         o_ct_inc,
  output logic                     o_a0_wb,
  output logic [EXT_AW-1:0]        o_a0_next,
  output logic [RAM_AW-1:0]        o_ram_addr
`ifdef SCUDSP_DMA_ABORT_EN
  ,
  input  logic                     i_abort
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_REQ  = 2'd2,
    S_FIN  = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic                r_dir;
  logic [NBANK-1:0]    r_ramw;
  logic                r_prgw;
  logic [BSW-1:0]      r_rams;
  logic [EXT_AW-1:0]   r_inc;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_hold;
  logic [EXT_AW-1:0]   r_addr;
  logic [PRG_AW-1:0]   r_prg_addr;
  logic                r_aborted;
  logic                r_rd_q;
  logic [DATA_W-1:0]   r_dout;

  logic [EXT_AW-1:0]   w_start_inc;
  logic [NBANK-1:0]    w_src_oh;
  logic [NBANK-1:0]    w_dst_oh;
  logic [BSW-1:0]      w_dst_idx;
  logic [BSW-1:0]      w_bank_idx;
  logic [DATA_W-1:0]   w_rdata_sel;
  logic [RAM_AW-1:0]   w_ct_sel;
  logic                w_ack;
  logic                w_last;
  logic                w_abort;
  logic                w_in_xfer;

  assign w_in_xfer = (r_state == S_RD) || (r_state == S_REQ);

`ifdef SCUDSP_DMA_ABORT_EN
  assign w_abort = i_abort & i_ce & w_in_xfer;
`else
  assign w_abort = 1'b0;
`endif

  assign w_ack  = (r_state == S_REQ) & i_ce & i_ext_ack;
  assign w_last = (r_cnt == CNT_W'(1));

  // D0->RAM only honours the unit step; RAM->D0 uses the full power-of-two table.
  always_comb begin
    w_start_inc = '0;
    if (!i_dir) begin
      w_start_inc[0] = i_addi[0];
    end else if (i_addi != 3'd0) begin
      w_start_inc = EXT_AW'(1) << (i_addi - 3'd1);
    end
  end

  always_comb begin
    w_src_oh    = '0;
    w_dst_idx   = '0;
    w_rdata_sel = '0;
    for (int unsigned b = 0; b < NBANK; b++) begin
      if (BSW'(b) == r_rams) begin
        w_src_oh[b] = 1'b1;
        w_rdata_sel = i_ram_rdata[b*DATA_W +: DATA_W];
      end
      if (r_ramw[b]) begin
        w_dst_idx = BSW'(b);
      end
    end
  end

  assign w_dst_oh   = r_prgw ? '0 : r_ramw;
  assign w_bank_idx = r_dir ? r_rams : w_dst_idx;

  always_comb begin
    w_ct_sel = '0;
    for (int unsigned b = 0; b < NBANK; b++) begin
      if (BSW'(b) == w_bank_idx) begin
        w_ct_sel = i_ram_ct[b*RAM_AW +: RAM_AW];
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (i_start) w_next = i_dir ? S_RD : S_REQ;
      S_RD:   w_next = w_abort ? S_FIN : S_REQ;
      S_REQ: begin
        if (w_ack) begin
          w_next = (w_last || w_abort) ? S_FIN : (r_dir ? S_RD : S_REQ);
        end else if (w_abort) begin
          w_next = S_FIN;
        end
      end
      S_FIN:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_dir      <= 1'b0;
      r_ramw     <= '0;
      r_prgw     <= 1'b0;
      r_rams     <= '0;
      r_inc      <= '0;
      r_cnt      <= '0;
      r_hold     <= 1'b0;
      r_addr     <= '0;
      r_prg_addr <= '0;
      r_aborted  <= 1'b0;
      r_rd_q     <= 1'b0;
      r_dout     <= '0;
    end else begin
      // RAM read data arrives one clock after RE regardless of CE; hold it for slow ACKs.
      r_rd_q <= (r_state == S_RD);
      if (r_rd_q) r_dout <= w_rdata_sel;
      if (i_ce) begin
        r_state <= w_next;
        if ((r_state == S_IDLE) && i_start) begin
          r_dir      <= i_dir;
          r_ramw     <= i_ramw;
          r_prgw     <= i_prgw;
          r_rams     <= i_rams;
          r_inc      <= w_start_inc;
          r_cnt      <= i_cnt;
          r_hold     <= i_hold;
          r_addr     <= i_ext_a0;
          r_prg_addr <= '0;
          r_aborted  <= 1'b0;
        end
        if (w_ack) begin
          r_addr <= r_addr + r_inc;
          r_cnt  <= r_cnt - CNT_W'(1);
          if (!r_dir && r_prgw) r_prg_addr <= r_prg_addr + PRG_AW'(1);
        end
        if (w_abort) r_aborted <= 1'b1;
      end
    end
  end

  assign o_busy      = (r_state != S_IDLE);
  assign o_ext_req   = (r_state == S_REQ) & ~(w_abort & ~w_ack);
  assign o_ext_we    = o_ext_req & r_dir;
  assign o_ext_addr  = r_addr;
  assign o_a0_next   = r_addr;
  assign o_ext_dout  = ((r_state == S_REQ) && r_dir) ? (r_rd_q ? w_rdata_sel : r_dout) : '0;
  assign o_ram_re    = (r_state == S_RD) ? w_src_oh : '0;
  assign o_ram_we    = (w_ack && !r_dir) ? w_dst_oh : '0;
  assign o_ram_wdata = ((r_state == S_REQ) && !r_dir) ? i_ext_din : '0;
  assign o_prg_we    = w_ack & ~r_dir & r_prgw;
  assign o_prg_addr  = r_prg_addr;
  assign o_ct_inc    = w_ack ? (r_dir ? w_src_oh : w_dst_oh) : '0;
  assign o_done      = (r_state == S_FIN) & i_ce;
  assign o_a0_wb     = o_done & ~r_hold & ~r_aborted;
  assign o_ram_addr  = o_busy ? w_ct_sel : '0;

endmodule
